// File: rtl/irq_mon_pkg.sv
// Shared types for the interrupt protocol monitor: operating modes and per-line states.
package irq_mon_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        HOLD = 2'd1,
        FREE = 2'd2
    } irq_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_CLR
    } irq_line_state_e;

    // Encoding 2'd3 behaves like FREE, so "free" is simply the upper mode bit.
    function automatic logic mode_is_free(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/irq_line_tracker.sv
// One interrupt line: raise/ack/clear FSM plus a saturating pending-latency counter.
module irq_line_tracker
    import irq_mon_pkg::*;
#(
    parameter int MAX_ACK_LAT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    input  logic ack_hit_i,
    input  logic free_i,
    output logic pending_o,
    output logic ack_ok_o,
    output logic drop_violation_o,
    output logic latency_err_o
);

    localparam int LAT_W = (MAX_ACK_LAT > 0) ? $clog2(MAX_ACK_LAT + 1) : 1;

    irq_line_state_e  state_q, state_d;
    logic             clr_hi_q, clr_hi_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             lat_en;

    assign lat_en = (MAX_ACK_LAT > 0) && !free_i;

    // Next-state logic for the line FSM and its latency counter.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        clr_hi_d = 1'b0;
        lat_d    = '0;
        case (state_q)
            IDLE: begin
                // A raise coinciding with its own ack skips straight past WAIT_ACK.
                if (irq_i) state_d = ack_hit_i ? WAIT_CLR : WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_hit_i)            state_d = WAIT_CLR;
                else if (!irq_i && free_i) state_d = IDLE;
                lat_d = lat_q;
                if (lat_en && (int'(lat_q) < MAX_ACK_LAT)) lat_d = lat_q + LAT_W'(1);
            end
            WAIT_CLR: begin
                // Second consecutive high cycle after the ack counts as a fresh raise.
                if (!irq_i)        state_d  = IDLE;
                else if (clr_hi_q) state_d  = WAIT_ACK;
                else               clr_hi_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, re-raise tracker and latency counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q  <= IDLE;
            clr_hi_q <= 1'b0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            clr_hi_q <= clr_hi_d;
            lat_q    <= lat_d;
        end
    end

    assign pending_o        = (state_q == WAIT_ACK);
    assign ack_ok_o         = pending_o || (irq_i && (state_q == IDLE));
    assign drop_violation_o = pending_o && !irq_i;
    // Fires on the cycle whose edge brings the counter to MAX_ACK_LAT without an ack.
    assign latency_err_o    = lat_en && pending_o && !ack_hit_i &&
                              (int'(lat_q) >= MAX_ACK_LAT - 1);

endmodule

// File: rtl/irq_protocol_monitor.sv
// Interrupt interface monitor: per-line trackers, ack legality, sticky errors, ack counter.
module irq_protocol_monitor
    import irq_mon_pkg::*;
#(
    parameter int NUM_IRQ     = 32,
    parameter int ID_W        = 5,
    parameter int MAX_ACK_LAT = 64,
    parameter int CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         mode_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               irq_ack_o,
    input  logic [ID_W-1:0]    irq_id_o,
    output logic [NUM_IRQ-1:0] pending_o,
    output logic               env_ok_o,
    output logic               err_spurious_o,
    output logic               err_range_o,
    output logic               err_latency_o,
    output logic [CNT_W-1:0]   ack_cnt_o
);

    logic               free;
    logic               id_in_range;
    logic               ack_legal;
    logic [NUM_IRQ-1:0] ack_hit, ack_ok, drop_vio, lat_err;

    logic             err_spur_q, err_spur_d;
    logic             err_range_q, err_range_d;
    logic             err_lat_q, err_lat_d;
    logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;

    assign free        = mode_is_free(mode_i);
    assign id_in_range = int'(irq_id_o) < NUM_IRQ;

    for (genvar n = 0; n < NUM_IRQ; n++) begin : g_line
        assign ack_hit[n] = irq_ack_o && (int'(irq_id_o) == n);

        irq_line_tracker #(
            .MAX_ACK_LAT(MAX_ACK_LAT)
        ) u_line (
            .clk_i           (clk_i),
            .rst_i           (rst_i),
            .irq_i           (irq_i[n]),
            .ack_hit_i       (ack_hit[n]),
            .free_i          (free),
            .pending_o       (pending_o[n]),
            .ack_ok_o        (ack_ok[n]),
            .drop_violation_o(drop_vio[n]),
            .latency_err_o   (lat_err[n])
        );
    end

    // An out-of-range id hits no line, so it can never count as legal.
    assign ack_legal = |(ack_hit & ack_ok);

    // Stimulus legality for the current mode.
    always_comb begin
        env_ok_o = 1'b1;
        case (mode_i)
            OFF:     env_ok_o = (irq_i == '0);
            HOLD:    env_ok_o = (drop_vio == '0);
            default: env_ok_o = 1'b1;
        endcase
    end

    // Sticky error accumulation and saturating legal-ack count.
    always_comb begin
        err_spur_d  = err_spur_q  | (irq_ack_o && id_in_range && !ack_legal);
        err_range_d = err_range_q | (irq_ack_o && !id_in_range);
        err_lat_d   = err_lat_q   | (|lat_err);
        ack_cnt_d   = ack_cnt_q;
        if (ack_legal && (ack_cnt_q != '1)) ack_cnt_d = ack_cnt_q + CNT_W'(1);
    end

    // Error and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_spur_q  <= 1'b0;
            err_range_q <= 1'b0;
            err_lat_q   <= 1'b0;
            ack_cnt_q   <= '0;
        end else begin
            err_spur_q  <= err_spur_d;
            err_range_q <= err_range_d;
            err_lat_q   <= err_lat_d;
            ack_cnt_q   <= ack_cnt_d;
        end
    end

    assign err_spurious_o = err_spur_q;
    assign err_range_o    = err_range_q;
    assign err_latency_o  = err_lat_q;
    assign ack_cnt_o      = ack_cnt_q;

endmodule

// File: tb/tb_irq_protocol_monitor.sv
// Directed scenario bench for irq_protocol_monitor (19 lines, latency limit 4, 2-bit counter).
module tb_irq_protocol_monitor;
    import irq_mon_pkg::*;

    localparam int N    = 19;
    localparam int IDW  = 5;
    localparam int LAT  = 4;
    localparam int CW   = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     mode = HOLD;
    logic [N-1:0]   irq = '0;
    logic           ack = 1'b0;
    logic [IDW-1:0] id = '0;
    logic [N-1:0]   pending;
    logic           env_ok, err_spur, err_range, err_lat;
    logic [CW-1:0]  cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_protocol_monitor #(
        .NUM_IRQ(N), .ID_W(IDW), .MAX_ACK_LAT(LAT), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .irq_i(irq),
        .irq_ack_o(ack), .irq_id_o(id), .pending_o(pending), .env_ok_o(env_ok),
        .err_spurious_o(err_spur), .err_range_o(err_range), .err_latency_o(err_lat),
        .ack_cnt_o(cnt)
    );

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        irq = '0; ack = 1'b0; id = '0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        #3;
        checks++; if (pending !== '0) begin errors++; $display("FAIL rst_hold_pending got %h exp 0", pending); end
        checks++; if ({err_spur, err_range, err_lat} !== 3'b000) begin errors++; $display("FAIL rst_hold_err got %b exp 000", {err_spur, err_range, err_lat}); end
        checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL rst_hold_cnt got %0d exp 0", cnt); end
        rst = 1'b0;
        tick();
        mode = HOLD; irq[7] = 1'b1;
        tick();
        checks++; if (pending !== 19'h00080) begin errors++; $display("FAIL l7_pending got %h exp 00080", pending); end
        ack = 1'b1; id = 5'd7;
        tick();
        ack = 1'b0;
        checks++; if (pending !== '0) begin errors++; $display("FAIL l7_acked got %h exp 0", pending); end
        checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL l7_cnt got %0d exp 1", cnt); end
        tick();
        checks++; if (pending !== '0) begin errors++; $display("FAIL l7_clr1 got %h exp 0", pending); end
        tick();
        checks++; if (pending !== 19'h00080) begin errors++; $display("FAIL l7_reraise got %h exp 00080", pending); end
        ack = 1'b1; id = 5'd3;
        tick();
        ack = 1'b0;
        checks++; if (err_spur !== 1'b1) begin errors++; $display("FAIL pre_rst_spur got %b exp 1", err_spur); end
        #2 rst = 1'b1;
        #1;
        checks++; if (pending !== '0) begin errors++; $display("FAIL midrst_pending got %h exp 0", pending); end
        checks++; if ({err_spur, err_range, err_lat} !== 3'b000) begin errors++; $display("FAIL midrst_err got %b exp 000", {err_spur, err_range, err_lat}); end
        checks++; if (cnt !== 2'd0) begin errors++; $display("FAIL midrst_cnt got %0d exp 0", cnt); end
        irq = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_hold_ack;
        mode = HOLD; irq = '0; irq[11] = 1'b1;
        tick();
        checks++; if (pending !== 19'h00800) begin errors++; $display("FAIL hold_pending got %h exp 00800", pending); end
        checks++; if (env_ok !== 1'b1) begin errors++; $display("FAIL hold_env got %b exp 1", env_ok); end
        tick();
        tick();
        ack = 1'b1; id = 5'd11;
        tick();
        ack = 1'b0; irq = '0;
        #1;
        checks++; if (pending !== '0) begin errors++; $display("FAIL hold_acked got %h exp 0", pending); end
        checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL hold_cnt got %0d exp 1", cnt); end
        checks++; if (env_ok !== 1'b1) begin errors++; $display("FAIL hold_drop_after_ack_env got %b exp 1", env_ok); end
        tick();
        checks++; if ({err_spur, err_range, err_lat} !== 3'b000) begin errors++; $display("FAIL hold_err got %b exp 000", {err_spur, err_range, err_lat}); end
    endtask

    task automatic test_spurious;
        ack = 1'b1; id = 5'd3;
        tick();
        ack = 1'b0;
        checks++; if (err_spur !== 1'b1) begin errors++; $display("FAIL spur_set got %b exp 1", err_spur); end
        checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL spur_cnt got %0d exp 1", cnt); end
        checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL spur_range got %b exp 0", err_range); end
        tick();
        tick();
        checks++; if (err_spur !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b exp 1", err_spur); end
    endtask

    task automatic test_range;
        do_reset();
        ack = 1'b1; id = 5'd19;
        tick();
        ack = 1'b0;
        checks++; if (err_range !== 1'b1) begin errors++; $display("FAIL range19 got %b exp 1", err_range); end
        checks++; if (err_spur !== 1'b0) begin errors++; $display("FAIL range19_spur got %b exp 0", err_spur); end
        do_reset();
        irq[18] = 1'b1; ack = 1'b1; id = 5'd18;
        tick();
        ack = 1'b0; irq = '0;
        checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL raise_ack18_cnt got %0d exp 1", cnt); end
        checks++; if ({err_spur, err_range} !== 2'b00) begin errors++; $display("FAIL raise_ack18_err got %b exp 00", {err_spur, err_range}); end
        checks++; if (pending !== '0) begin errors++; $display("FAIL raise_ack18_pending got %h exp 0", pending); end
        ack = 1'b1; id = 5'd25;
        tick();
        ack = 1'b0;
        checks++; if (err_range !== 1'b1) begin errors++; $display("FAIL range25 got %b exp 1", err_range); end
        checks++; if (err_spur !== 1'b0) begin errors++; $display("FAIL range25_spur got %b exp 0", err_spur); end
        checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL range25_cnt got %0d exp 1", cnt); end
    endtask

    task automatic test_latency;
        do_reset();
        mode = HOLD; irq[16] = 1'b1;
        tick();
        tick();
        tick();
        tick();
        checks++; if (err_lat !== 1'b0) begin errors++; $display("FAIL lat_early got %b exp 0", err_lat); end
        tick();
        checks++; if (err_lat !== 1'b1) begin errors++; $display("FAIL lat_hit got %b exp 1", err_lat); end
        tick();
        checks++; if (err_lat !== 1'b1) begin errors++; $display("FAIL lat_sticky got %b exp 1", err_lat); end
        checks++; if (pending !== 19'h10000) begin errors++; $display("FAIL lat_pending got %h exp 10000", pending); end
        do_reset();
        mode = FREE; irq[16] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (err_lat !== 1'b0) begin errors++; $display("FAIL lat_free got %b exp 0", err_lat); end
        checks++; if (pending !== 19'h10000) begin errors++; $display("FAIL lat_free_pending got %h exp 10000", pending); end
        mode = HOLD;
    endtask

    task automatic test_env;
        do_reset();
        mode = OFF;
        #1;
        checks++; if (env_ok !== 1'b1) begin errors++; $display("FAIL off_quiet_env got %b exp 1", env_ok); end
        irq[0] = 1'b1;
        #1;
        checks++; if (env_ok !== 1'b0) begin errors++; $display("FAIL off_irq_env got %b exp 0", env_ok); end
        irq = '0; ack = 1'b1; id = 5'd4;
        tick();
        ack = 1'b0;
        checks++; if (err_spur !== 1'b1) begin errors++; $display("FAIL off_ack_checked got %b exp 1", err_spur); end
        do_reset();
        mode = HOLD; irq[5] = 1'b1;
        tick();
        checks++; if (env_ok !== 1'b1) begin errors++; $display("FAIL hold_high_env got %b exp 1", env_ok); end
        irq = '0;
        #1;
        checks++; if (env_ok !== 1'b0) begin errors++; $display("FAIL hold_drop_env got %b exp 0", env_ok); end
        tick();
        checks++; if (pending !== 19'h00020) begin errors++; $display("FAIL hold_drop_kept got %h exp 00020", pending); end
        mode = FREE;
        #1;
        checks++; if (env_ok !== 1'b1) begin errors++; $display("FAIL free_drop_env got %b exp 1", env_ok); end
        tick();
        checks++; if (pending !== '0) begin errors++; $display("FAIL free_drop_idle got %h exp 0", pending); end
        checks++; if (err_lat !== 1'b0) begin errors++; $display("FAIL free_drop_lat got %b exp 0", err_lat); end
        mode = HOLD;
    endtask

    task automatic test_saturation;
        logic [CW-1:0] exp_cnt;
        do_reset();
        mode = HOLD;
        for (int n = 1; n <= 4; n++) begin
            irq = '0; irq[n] = 1'b1; ack = 1'b1; id = IDW'(n);
            tick();
            ack = 1'b0; irq = '0;
            exp_cnt = (n < 3) ? CW'(n) : 2'd3;
            checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL sat_cnt_%0d got %0d exp %0d", n, cnt, exp_cnt); end
        end
        checks++; if (err_spur !== 1'b0) begin errors++; $display("FAIL sat_spur got %b exp 0", err_spur); end
    endtask

    initial begin
        test_reset();
        test_hold_ack();
        test_spurious();
        test_range();
        test_latency();
        test_env();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
